vec_exec_unit: RTL
==================

# vec_exec_unit

Multi-beat vector execute unit for the vector ASIP core. It accepts one conditionally executed vector ALU instruction per handshake and processes VLEN elements PAR lanes per cycle. It keeps the NZCV flag register that governs condition evaluation and returns the full result vector through a valid/ready output port. It generalises the scalar execute stage (2-bit ALU control, 4-bit condition, 2-bit flag-write) to parametrised element width, vector length and lane parallelism, and adds saturating ops, backpressure and flush.

## Interface
- ELEM_W, 8, element width in bits (≥2)
- VLEN, 8, elements per vector
- PAR, 4, lanes computed per cycle; VLEN % PAR == 0; B = VLEN/PAR beats
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous abort of the in-flight instruction
- in_valid  in  1  instruction offered
- in_ready  out  1  unit can accept
- in_op  in  3  operation code
- in_cond  in  4  condition code
- in_flagw  in  2  bit1: write N,Z; bit0: write C,V
- in_a, in_b  in  VLEN*ELEM_W  operands; element i at [i*ELEM_W +: ELEM_W]
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_result  out  VLEN*ELEM_W  result vector
- out_exec  out  1  1 = executed, 0 = condition failed
- flags  out  4  {N,Z,C,V} register

## Operation
- FSM states: IDLE, RUN, DONE.
- in_ready = ~rst & (IDLE | (DONE & out_ready)). Acceptance happens on in_valid & in_ready. At acceptance the unit latches the op, operands and flagw, and evaluates cond against the current flags.
- Conditions, ARM encoding: 0000 EQ Z, 0001 NE !Z, 0010 CS C, 0011 CC !C, 0100 MI N, 0101 PL !N, 0110 VS V, 0111 VC !V, 1000 HI C&!Z, 1001 LS !C|Z, 1010 GE N==V, 1011 LT N!=V, 1100 GT !Z&(N==V), 1101 LE Z|(N!=V), 1110 AL, 1111 also always.
- Condition pass: go to RUN with beat counter 0. Beat k computes elements k*PAR..k*PAR+PAR-1 into the result register. After beat B-1, go to DONE with out_exec=1.
- Condition fail: go directly to DONE with out_exec=0, out_result all zero, flags untouched.
- Ops:
  - 000 ADD a+b
  - 001 SUB a−b
  - 010 AND
  - 011 ORR
  - 100 EOR
  - 101 SATADD: unsigned, clamp at all-ones
  - 110 SATSUB: unsigned, clamp at 0
  - 111 MOVB: result = b
  - Arithmetic is modulo 2^ELEM_W except for the saturating ops.
- Flag accumulation across beats, over all VLEN elements:
  - N = OR of result element MSBs
  - Z = AND of (element == 0)
  - C = element 0 raw carry (ADD/SATADD: carry-out; SUB/SATSUB: no-borrow, a≥b)
  - V = OR of raw signed overflow
  - Raw means computed before saturation.
- Flag write happens on the RUN→DONE edge, only when executed. flagw[1] writes N,Z. flagw[0] writes C,V, and only for ops 000, 001, 101, 110; logical ops and MOVB never change C,V.
- DONE holds out_valid=1 with result, exec and flags stable until out_ready. If in_valid is also high in that cycle, the next instruction is accepted in the same cycle (IDLE is skipped).
- flush (priority below rst, above everything else): return to IDLE, out_valid=0, flags unchanged, no flag write. This holds even when flush coincides with the final beat.

## Timing
- Reset values: state IDLE, out_valid 0, out_result 0, out_exec 0, flags 0000, beat counter 0; in_ready 0 during rst, 1 on the first cycle after.
- Accept at edge T; out_valid rises after edge T+B (executed) or T+1 (condition failed).
- Throughput with out_ready held high: one instruction per B+1 cycles (executed) or per 2 cycles (failed).
- Flags seen by an instruction accepted in the DONE-handoff cycle are the values already written by the completing instruction.
- All outputs are registered except in_ready.

## Test plan
With ELEM_W=8, VLEN=8, PAR=4 (B=2):
1. ADD, a[i]=0x10+i, b[i]=0x01, cond AL, flagw 11 → out_valid 2 cycles after accept, result[i]=0x11+i, exec 1, flags 0000.
2. SUB with a=b=0x55 all elements, flagw 11 → result zero, flags N0 Z1 C1 V0. Next, ORR cond EQ executes (exec 1); then ADD cond NE → out_valid 1 cycle after accept, exec 0, result 0, flags still 0110.
3. SATADD a=0xF0, b=0x20 → all 0xFF, C=1. SATSUB a=0x10, b=0x20 → all 0x00, C=0. ADD a=0x7F, b=0x01 → 0x80, N=1, V=1.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid → result, exec and flags stable, in_ready 0. Then raise out_ready with in_valid=1 → new instruction accepted in that same cycle, out_valid drops next cycle.
5. Flush asserted during beat 1 of an ADD with flagw 11 → out_valid never rises, flags unchanged, in_ready=1 next cycle, following instruction completes normally.
6. rst asserted mid-RUN and in DONE → all outputs take reset values next cycle, flags 0000, in_ready 0 while rst is high.

Source files
------------

// File: rtl/vec_exec_unit.sv
// vec_exec_unit: multi-beat, conditionally executed vector ALU stage.
//   Accepts one instruction per in_valid/in_ready handshake, evaluates its
//   condition against the NZCV register at acceptance, computes VLEN elements
//   PAR lanes per beat, and holds the full result on a valid/ready port.
// Ports:
//   clk, rst (sync, active-high), flush (sync abort of in-flight instruction)
//   in_valid/in_ready, in_op[2:0], in_cond[3:0], in_flagw[1:0], in_a, in_b
//   out_valid/out_ready, out_result, out_exec (1 = executed), flags {N,Z,C,V}
module vec_exec_unit #(
  parameter int ELEM_W = 8,
  parameter int VLEN   = 8,
  parameter int PAR    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [3:0]               in_cond,
  input  logic [1:0]               in_flagw,
  input  logic [VLEN*ELEM_W-1:0]   in_a,
  input  logic [VLEN*ELEM_W-1:0]   in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [VLEN*ELEM_W-1:0]   out_result,
  output logic                     out_exec,
  output logic [3:0]               flags
);

  localparam int unsigned W  = VLEN * ELEM_W;
  localparam int unsigned EW = ELEM_W;
  localparam int unsigned P  = PAR;
  localparam int unsigned B  = VLEN / PAR;
  localparam int unsigned BW = (B > 1) ? $clog2(B) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef enum logic [2:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_AND    = 3'b010,
    OP_ORR    = 3'b011,
    OP_EOR    = 3'b100,
    OP_SATADD = 3'b101,
    OP_SATSUB = 3'b110,
    OP_MOVB   = 3'b111
  } op_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  op_t             op_q, op_d;
  logic [1:0]      flagw_q, flagw_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic            pass_q, pass_d;
  logic [W-1:0]    res_q, res_d;
  logic            exec_q, exec_d;
  logic            valid_q, valid_d;
  logic [3:0]      flags_q, flags_d;
  logic            acc_n_q, acc_n_d, acc_z_q, acc_z_d;
  logic            acc_c_q, acc_c_d, acc_v_q, acc_v_d;

  logic            accept;
  logic            arith_op;
  int unsigned     idx;
  logic [EW-1:0]   ea, eb, r;
  logic [EW:0]     sum, dif;
  logic            c_raw, v_raw;

  // Odd codes invert the even base condition; 111x is always.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'b000:  base = z;
      3'b001:  base = cf;
      3'b010:  base = n;
      3'b011:  base = v;
      3'b100:  base = cf & ~z;
      3'b101:  base = (n == v);
      3'b110:  base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return (c[3:1] == 3'b111) ? 1'b1 : (base ^ c[0]);
  endfunction

  assign in_ready = ~rst & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign accept   = in_valid & in_ready;
  assign arith_op = op_q inside {OP_ADD, OP_SUB, OP_SATADD, OP_SATSUB};

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    op_d    = op_q;
    flagw_d = flagw_q;
    a_d     = a_q;
    b_d     = b_q;
    pass_d  = pass_q;
    res_d   = res_q;
    exec_d  = exec_q;
    valid_d = valid_q;
    flags_d = flags_q;
    acc_n_d = acc_n_q;
    acc_z_d = acc_z_q;
    acc_c_d = acc_c_q;
    acc_v_d = acc_v_q;
    idx     = 0;
    ea      = '0;
    eb      = '0;
    r       = '0;
    sum     = '0;
    dif     = '0;
    c_raw   = 1'b0;
    v_raw   = 1'b0;

    case (state_q)
      RUN: begin
        // A failed condition still spends one cycle here so the fail path
        // reports one cycle after acceptance.
        if (!pass_q) begin
          state_d = DONE;
          valid_d = 1'b1;
          exec_d  = 1'b0;
        end else begin
          for (int unsigned j = 0; j < P; j++) begin
            idx = int'(beat_q) * P + j;
            ea  = a_q[idx*EW +: EW];
            eb  = b_q[idx*EW +: EW];
            sum = {1'b0, ea} + {1'b0, eb};
            dif = {1'b0, ea} - {1'b0, eb};
            case (op_q)
              OP_ADD: begin
                r = sum[EW-1:0]; c_raw = sum[EW];
                v_raw = (ea[EW-1] == eb[EW-1]) && (sum[EW-1] != ea[EW-1]);
              end
              OP_SUB: begin
                r = dif[EW-1:0]; c_raw = ~dif[EW];
                v_raw = (ea[EW-1] != eb[EW-1]) && (dif[EW-1] != ea[EW-1]);
              end
              OP_SATADD: begin
                r = sum[EW] ? '1 : sum[EW-1:0]; c_raw = sum[EW];
                v_raw = (ea[EW-1] == eb[EW-1]) && (sum[EW-1] != ea[EW-1]);
              end
              OP_SATSUB: begin
                r = dif[EW] ? '0 : dif[EW-1:0]; c_raw = ~dif[EW];
                v_raw = (ea[EW-1] != eb[EW-1]) && (dif[EW-1] != ea[EW-1]);
              end
              OP_AND:  r = ea & eb;
              OP_ORR:  r = ea | eb;
              OP_EOR:  r = ea ^ eb;
              default: r = eb;
            endcase
            res_d[idx*EW +: EW] = r;
            acc_n_d = acc_n_d | r[EW-1];
            acc_z_d = acc_z_d & (r == '0);
            acc_v_d = acc_v_d | v_raw;
            if (idx == 0) acc_c_d = c_raw;
          end

          if (beat_q == BW'(B - 1)) begin
            state_d = DONE;
            valid_d = 1'b1;
            exec_d  = 1'b1;
            if (flagw_q[1]) begin
              flags_d[3] = acc_n_d;
              flags_d[2] = acc_z_d;
            end
            if (flagw_q[0] && arith_op) begin
              flags_d[1] = acc_c_d;
              flags_d[0] = acc_v_d;
            end
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    // Acceptance in DONE overrides the return to IDLE (same-cycle handoff).
    if (accept) begin
      state_d = RUN;
      beat_d  = '0;
      op_d    = op_t'(in_op);
      flagw_d = in_flagw;
      a_d     = in_a;
      b_d     = in_b;
      pass_d  = cond_ok(in_cond, flags_q);
      res_d   = '0;
      exec_d  = 1'b0;
      valid_d = 1'b0;
      acc_n_d = 1'b0;
      acc_z_d = 1'b1;
      acc_c_d = 1'b0;
      acc_v_d = 1'b0;
    end

    if (flush) begin
      state_d = IDLE;
      beat_d  = '0;
      valid_d = 1'b0;
      flags_d = flags_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      op_q    <= OP_ADD;
      flagw_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      pass_q  <= 1'b0;
      res_q   <= '0;
      exec_q  <= 1'b0;
      valid_q <= 1'b0;
      flags_q <= '0;
      acc_n_q <= 1'b0;
      acc_z_q <= 1'b1;
      acc_c_q <= 1'b0;
      acc_v_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      op_q    <= op_d;
      flagw_q <= flagw_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pass_q  <= pass_d;
      res_q   <= res_d;
      exec_q  <= exec_d;
      valid_q <= valid_d;
      flags_q <= flags_d;
      acc_n_q <= acc_n_d;
      acc_z_q <= acc_z_d;
      acc_c_q <= acc_c_d;
      acc_v_q <= acc_v_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_result = res_q;
  assign out_exec   = exec_q;
  assign flags      = flags_q;

endmodule
